timer_sched_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/timer_sched_ctrl.sv | 161 ++++++++++++++++
 tb/tb_timer_sched_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer: Avalon interval-timer register
// addresses, control register bit positions, the sequencer state encoding and
// a helper that builds a control register write word.
package timer_pkg;

   // Timer slave register addresses
   localparam logic [2:0] TMR_STATUS   = 3'd0;
   localparam logic [2:0] TMR_CONTROL  = 3'd1;
   localparam logic [2:0] TMR_PERIOD_L = 3'd2;
   localparam logic [2:0] TMR_PERIOD_H = 3'd3;

   // Control register bit positions
   localparam int unsigned CTRL_ITO   = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_START = 2;
   localparam int unsigned CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      StIdle,
      StWrPl,
      StWrPh,
      StWrClr,
      StWrCtl,
      StWait,
      StStop,
      StAckD,
      StAckA,
      StDone,
      StAbort
   } state_e;

   function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                             input logic start, input logic stop);
      logic [15:0] w;
      w             = '0;
      w[CTRL_ITO]   = ito;
      w[CTRL_CONT]  = cont;
      w[CTRL_START] = start;
      w[CTRL_STOP]  = stop;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker. Searches req_mask starting at index ptr, ascending with
// wrap-around, and returns the first set bit.
//   req_mask  in   NUM_REQ  eligible requesters
//   ptr       in   IDX_W    index where the search starts
//   grant     out  NUM_REQ  one-hot winner (0 when req_mask is 0)
//   idx       out  IDX_W    index of the winner (0 when req_mask is 0)
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   always_comb begin
      logic              found;
      int unsigned       cw;
      logic [IDX_W-1:0]  c;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cw    = 0;
      c     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cw = 32'(ptr) + k;
         if (cw >= NUM_REQ) cw = cw - NUM_REQ;
         c = IDX_W'(cw);
         if (!found && req_mask[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end

endmodule

// File: rtl/timer_sched_ctrl.sv
// Time-shares one Avalon interval timer between NUM_REQ requesters. A winner
// is picked round-robin, the timer is programmed for a one-shot delay of
// req_count ticks, and the owner gets a done pulse on irq or an aborted pulse
// when it cancels or drops its request.
//   clk, reset_n    clock, asynchronous active-low reset
//   req/cancel      per-requester level request and abort
//   req_count       per-requester delay, slice i = [i*CNT_W +: CNT_W]
//   grant/busy      current owner (one-hot) and ownership flag
//   done/aborted    one-cycle completion pulses
//   tmr_*           registered Avalon-MM write master to the timer, tmr_irq in
module timer_sched_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] req_count,
   input  logic [NUM_REQ-1:0]       cancel,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic [NUM_REQ-1:0]       aborted,
   output logic                     busy,
   output logic [2:0]               tmr_address,
   output logic                     tmr_chipselect,
   output logic                     tmr_write_n,
   output logic [15:0]              tmr_writedata,
   input  logic                     tmr_irq
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_m1;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] arb_grant, owner_oh;
   logic [IDX_W-1:0]   arb_idx;

   logic [NUM_REQ-1:0] grant_d, done_d, aborted_d;
   logic               busy_d, cs_d, wn_d;
   logic [2:0]         addr_d;
   logic [15:0]        data_d;

   // A cancelled requester is skipped, not serviced
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_mask (req & ~cancel),
      .ptr      (ptr_q),
      .grant    (arb_grant),
      .idx      (arb_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (|arb_grant) begin
               owner_d = arb_idx;
               cnt_d   = req_count[arb_idx*CNT_W +: CNT_W];
               state_d = (cnt_d == '0) ? StDone : StWrPl;
            end
         end
         StWrPl:  state_d = StWrPh;
         StWrPh:  state_d = StWrClr;
         StWrClr: state_d = StWrCtl;
         StWrCtl: state_d = StWait;
         StWait: begin
            // irq has priority over a same-cycle cancel
            if (tmr_irq)                               state_d = StAckD;
            else if (cancel[owner_q] || !req[owner_q]) state_d = StStop;
         end
         StStop: state_d = StAckA;
         StAckD: state_d = StDone;
         StAckA: state_d = StAbort;
         StDone, StAbort: begin
            ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered, so they are decoded from the next state
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_d] = 1'b1;
      cnt_m1            = cnt_d - 1'b1;
      grant_d           = (state_d == StIdle)  ? '0 : owner_oh;
      busy_d            = (state_d != StIdle);
      done_d            = (state_d == StDone)  ? owner_oh : '0;
      aborted_d         = (state_d == StAbort) ? owner_oh : '0;
      cs_d              = 1'b1;
      wn_d              = 1'b0;
      addr_d            = TMR_STATUS;
      data_d            = '0;
      unique case (state_d)
         StWrPl: begin
            addr_d = TMR_PERIOD_L;
            data_d = cnt_m1[15:0];
         end
         StWrPh: begin
            addr_d = TMR_PERIOD_H;
            data_d = cnt_m1[31:16];
         end
         StWrClr, StAckD, StAckA: begin
            addr_d = TMR_STATUS;
         end
         StWrCtl: begin
            addr_d = TMR_CONTROL;
            data_d = ctrl_word(1'b1, 1'b0, 1'b1, 1'b0);
         end
         StStop: begin
            addr_d = TMR_CONTROL;
            data_d = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
         end
         default: begin
            cs_d = 1'b0;
            wn_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         owner_q        <= '0;
         ptr_q          <= '0;
         grant          <= '0;
         done           <= '0;
         aborted        <= '0;
         busy           <= 1'b0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_address    <= '0;
         tmr_writedata  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         owner_q        <= owner_d;
         ptr_q          <= ptr_d;
         grant          <= grant_d;
         done           <= done_d;
         aborted        <= aborted_d;
         busy           <= busy_d;
         tmr_chipselect <= cs_d;
         tmr_write_n    <= wn_d;
         tmr_address    <= addr_d;
         tmr_writedata  <= data_d;
      end
   end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Bench for timer_sched_ctrl with a behavioural interval-timer model.
// Expected timer writes, grants and pulses are queued when stimulus is driven
// and popped as the DUT produces them.
module tb_timer_sched_ctrl;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   req;
   logic [127:0] req_count;
   logic [3:0]   cancel;
   logic [3:0]   grant, done, aborted;
   logic         busy;
   logic [2:0]   tmr_address;
   logic         tmr_chipselect, tmr_write_n;
   logic [15:0]  tmr_writedata;
   logic         tmr_irq;

   timer_sched_ctrl #(
      .NUM_REQ (4),
      .CNT_W   (32)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .req_count      (req_count),
      .cancel         (cancel),
      .grant          (grant),
      .done           (done),
      .aborted        (aborted),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   always #5 clk = ~clk;

   // Interval timer model: START loads the period, the count steps down once
   // per clock and the timeout flag sets on the clock after it reaches zero.
   logic [15:0] per_l, per_h;
   logic [31:0] tcnt;
   logic        running, to_flag, ito;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         per_l <= '0; per_h <= '0; tcnt <= '0;
         running <= 1'b0; to_flag <= 1'b0; ito <= 1'b0;
      end else begin
         if (running) begin
            if (tcnt == 32'd0) begin
               to_flag <= 1'b1;
               running <= 1'b0;
            end else begin
               tcnt <= tcnt - 32'd1;
            end
         end
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               3'd0: to_flag <= 1'b0;
               3'd1: begin
                  ito <= tmr_writedata[0];
                  if (tmr_writedata[3]) running <= 1'b0;
                  else if (tmr_writedata[2]) begin
                     running <= 1'b1;
                     tcnt    <= {per_h, per_l};
                  end
               end
               3'd2: per_l <= tmr_writedata;
               3'd3: per_h <= tmr_writedata;
               default: ;
            endcase
         end
      end
   end
   assign tmr_irq = to_flag & ito;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ctl_cyc = 0;
   int ctl_cnt = 0;
   int done_cyc = 0;
   int wr_cnt = 0;
   logic [3:0]  prev_grant = '0;
   logic [18:0] wq[$];
   logic [3:0]  gq[$];
   logic [7:0]  pq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and score whatever the DUT produced
   task automatic step();
      @(negedge clk);
      cyc++;
      if (tmr_chipselect && !tmr_write_n) begin
         wr_cnt++;
         if (wq.size() == 0) chk("unexpected_write", 32'({tmr_address, tmr_writedata}), 32'hDEAD_BEEF);
         else chk("write", 32'({tmr_address, tmr_writedata}), 32'(wq.pop_front()));
         if (tmr_address == 3'd1 && tmr_writedata == 16'h0005) begin
            ctl_cyc = cyc;
            ctl_cnt++;
         end
      end
      if (grant != 4'd0 && prev_grant == 4'd0) begin
         if (gq.size() == 0) chk("unexpected_grant", 32'(grant), 32'hDEAD_BEEF);
         else chk("grant", 32'(grant), 32'(gq.pop_front()));
      end
      prev_grant = grant;
      if ((done | aborted) != 4'd0) begin
         if (pq.size() == 0) chk("unexpected_pulse", 32'({aborted, done}), 32'hDEAD_BEEF);
         else chk("pulse", 32'({aborted, done}), 32'(pq.pop_front()));
         done_cyc = cyc;
         req = req & ~(done | aborted);
      end
   endtask

   task automatic push_prog(input logic [31:0] n);
      logic [31:0] m;
      m = n - 32'd1;
      wq.push_back({3'd2, m[15:0]});
      wq.push_back({3'd3, m[31:16]});
      wq.push_back({3'd0, 16'h0000});
      wq.push_back({3'd1, 16'h0005});
   endtask

   // Full successful job: program, irq ack, done pulse
   task automatic push_job(input int i, input logic [31:0] n);
      push_prog(n);
      wq.push_back({3'd0, 16'h0000});
      gq.push_back(4'(1 << i));
      pq.push_back(8'(1 << i));
   endtask

   task automatic set_req(input int i, input logic [31:0] n);
      req_count[i*32 +: 32] = n;
      req[i] = 1'b1;
   endtask

   task automatic wait_pulses(input string tag, input int budget);
      int n = 0;
      while (pq.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(pq.size()), 32'd0);
      pq.delete();
   endtask

   task automatic wait_ctl(input string tag, input int budget);
      int n = 0;
      int c0 = ctl_cnt;
      while (ctl_cnt == c0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(ctl_cnt - c0), 32'd1);
   endtask

   initial begin
      int n;
      int w0;
      int s0;
      reset_n   = 1'b0;
      req       = '0;
      cancel    = '0;
      req_count = '0;
      repeat (3) step();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cs_wn", 32'({tmr_chipselect, tmr_write_n}), 32'd1);
      chk("rst_addr_data", 32'({tmr_address, tmr_writedata}), 32'd0);
      reset_n = 1'b1;
      step();

      // All four at once, then requester 0 again after its done
      push_job(0, 20); push_job(1, 30); push_job(2, 40); push_job(3, 50);
      push_job(0, 20);
      set_req(0, 20); set_req(1, 30); set_req(2, 40); set_req(3, 50);
      n = 0;
      while (done[0] !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk("rr_first_done", 32'(done[0]), 32'd1);
      step(); step();
      set_req(0, 20);
      wait_pulses("rr_all_done", 1000);

      // Single request, count 100
      step();
      push_job(0, 100);
      set_req(0, 100);
      wait_pulses("single_done", 400);
      chk("single_latency", 32'(done_cyc - ctl_cyc), 32'd103);
      step();
      chk("single_grant_clear", 32'({busy, grant}), 32'd0);

      // 32-bit count split across both period registers
      push_job(2, 32'h0001_2345);
      set_req(2, 32'h0001_2345);
      wait_pulses("big_done", 80000);
      chk("big_latency", 32'(done_cyc - ctl_cyc), 32'h0001_2345 + 32'd3);

      // Cancel 10 cycles into WAIT
      push_prog(1000);
      wq.push_back({3'd1, 16'h0008});
      wq.push_back({3'd0, 16'h0000});
      gq.push_back(4'b0010);
      pq.push_back(8'b0010_0000);
      set_req(1, 1000);
      wait_ctl("cancel_ctl", 50);
      repeat (10) step();
      cancel[1] = 1'b1;
      wait_pulses("cancel_abort", 50);
      cancel[1] = 1'b0;
      n = 0;
      repeat (1100) begin
         step();
         if (tmr_irq) n++;
      end
      chk("cancel_irq_low", 32'(n), 32'd0);

      // irq and cancel in the same WAIT cycle: done wins
      push_job(3, 20);
      set_req(3, 20);
      wait_ctl("race_ctl", 50);
      n = 0;
      while (!tmr_irq && n < 100) begin
         step();
         n++;
      end
      chk("race_irq_seen", 32'(tmr_irq), 32'd1);
      cancel[3] = 1'b1;
      wait_pulses("race_done", 50);
      cancel[3] = 1'b0;
      step();

      // Zero count: immediate done, no timer traffic
      gq.push_back(4'b0100);
      pq.push_back(8'b0000_0100);
      w0 = wr_cnt;
      s0 = cyc;
      set_req(2, 0);
      wait_pulses("zero_done", 10);
      chk("zero_latency_le2", 32'((done_cyc - s0) <= 2), 32'd1);
      chk("zero_no_writes", 32'(wr_cnt - w0), 32'd0);
      step();

      // Reset during WAIT
      push_prog(500);
      gq.push_back(4'b0010);
      set_req(1, 500);
      wait_ctl("rstw_ctl", 50);
      repeat (5) step();
      reset_n = 1'b0;
      req     = '0;
      #1;
      chk("rstw_grant", 32'(grant), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_pulses", 32'({aborted, done}), 32'd0);
      chk("rstw_cs_wn", 32'({tmr_chipselect, tmr_write_n}), 32'd1);
      chk("rstw_addr_data", 32'({tmr_address, tmr_writedata}), 32'd0);
      repeat (2) step();
      reset_n = 1'b1;
      step();
      // Pointer restarts at 0, so requester 0 beats requester 3
      push_job(0, 15);
      push_job(3, 25);
      set_req(0, 15);
      set_req(3, 25);
      wait_pulses("post_reset_done", 300);
      repeat (3) step();
      chk("writes_all_seen", 32'(wq.size()), 32'd0);
      chk("grants_all_seen", 32'(gq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
